// File: rtl/decoder_pkg.sv
// decoder_pkg: shared mode and state encodings for the scanning decoder
package decoder_pkg;
  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_DIRECT  = 2'b01;
  localparam logic [1:0] MODE_SCAN    = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN,
    ST_ONESHOT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/decoder_nto2n.sv
// decoder_nto2n: combinational ADDR_W to 2**ADDR_W one-hot decoder
module decoder_nto2n #(
  parameter int ADDR_W = 4,
  localparam int OUT_W = 2 ** ADDR_W
) (
  input  logic [ADDR_W-1:0] a,
  output logic [OUT_W-1:0]  y
);
  assign y = {{(OUT_W-1){1'b0}}, 1'b1} << a;
endmodule

// File: rtl/decoder_scan_nto2n.sv
// decoder_scan_nto2n: registered one-hot selector, direct decode or timed scan
module decoder_scan_nto2n
  import decoder_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DWELL_W = 8,
  localparam int OUT_W  = 2 ** ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic               addr_valid,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   d,
  output logic [ADDR_W-1:0]  cur_addr,
  output logic               busy,
  output logic               done
);
  state_t state, state_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [OUT_W-1:0] dec;
  logic on_nx, busy_nx, done_nx, last_step;
  assign last_step = state == ST_ONESHOT && cnt == '0 && &cur_addr;
  decoder_nto2n #(.ADDR_W(ADDR_W)) u_dec (.a(addr_nx), .y(dec));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur_addr <= '0;
      d        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cur_addr <= addr_nx;
      d        <= on_nx ? dec : '0;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end
  // DONE is sticky while mode stays ONESHOT; re-arming needs a mode or en change
  always_comb begin
    state_nx = !en || mode == MODE_OFF ? ST_IDLE
             : mode == MODE_DIRECT     ? ST_DIRECT
             : mode == MODE_SCAN       ? ST_SCAN
             : state == ST_DONE || last_step ? ST_DONE : ST_ONESHOT;
  end
  always_comb begin
    addr_nx = cur_addr;
    cnt_nx  = cnt;
    on_nx   = |d;
    busy_nx = 1'b0;
    done_nx = 1'b0;
    if (state_nx == ST_DIRECT) begin
      addr_nx = addr_valid ? addr_in : state != ST_DIRECT ? '0 : cur_addr;
      on_nx   = addr_valid || (state == ST_DIRECT && |d);
    end else if (state_nx == ST_SCAN || state_nx == ST_ONESHOT) begin
      busy_nx = 1'b1;
      on_nx   = 1'b1;
      if (state != state_nx) begin
        addr_nx = '0;
        cnt_nx  = dwell;
      end else if (cnt == '0) begin
        addr_nx = cur_addr + 1'b1;
        cnt_nx  = dwell;
      end else begin
        cnt_nx = cnt - 1'b1;
      end
    end else begin
      addr_nx = '0;
      cnt_nx  = '0;
      on_nx   = 1'b0;
      done_nx = state == ST_ONESHOT && state_nx == ST_DONE;
    end
  end
endmodule
